mem_skew_reader: RTL and testbench
==================================

Name: mem_skew_reader

Overview:
- Read-side sequencer for the 4x4 operand memory (per-column read enables, per-column 2-bit row selects, asynchronous read).
- On a start pulse it walks the memory in diagonal-skewed order, so column i receives row (t-i) at step t. This produces the wavefront needed to feed one edge of the systolic array.
- It registers the returned data and presents it with per-column valid flags to the array edge.
- It supports a hold/stall input and start/busy/done handshaking toward the top-level controller.

Parameters:
- DATA_WIDTH, 8, width of one memory cell / array operand.
- N, 4, array dimension (columns and rows). Fixed at 4 for this revision; row select is 2 bits per column.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin one skewed read pass; sampled only in IDLE.
- hold  in  1  stall. While high, the step counter, memory controls and output registers freeze.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- done  out  1  one-cycle pulse in the DONE state.
- mem_read_enable  out  4  bit i enables memory column i.
- mem_read_elem  out  8  2 bits per column (bits [2i+1:2i]): the row read by column i.
- mem_data  in  4*DATA_WIDTH  asynchronous memory read data; column i in bits [i*DW +: DW].
- feed_data  out  4*DATA_WIDTH  registered operands to the array edge; same column packing.
- feed_valid  out  4  registered per-column valid, aligned with feed_data.

Behaviour:
- Reset (async, rst_n low): state=IDLE, step=0, busy=0, done=0, mem_read_enable=0, mem_read_elem=0, feed_data=0, feed_valid=0. Reset mid-pass aborts the pass immediately. No done pulse is issued for an aborted pass.
- States: IDLE, FEED, DONE.
  - IDLE: all memory controls 0. On start=1 at a rising edge → FEED with step=0.
  - FEED: step counts 0..2N-2 (0..6). Each non-held cycle step increments. At step 6, next state is DONE.
  - DONE: busy=1, done=1, controls 0. Next cycle → IDLE unconditionally.
- Memory control outputs are combinational from state and step. In FEED, for each column i:
  - enable_i = (step >= i) && (step - i <= N-1);
  - mem_read_elem[2i+:2] = step - i when enabled, else 2'b00.
- Output registers: each non-held rising edge, feed_valid[i] <= enable_i, and feed_data col i <= mem_data col i if enable_i else 0. Latency from issued read to feed_valid is 1 cycle.
- Timeline: start sampled at edge E → FEED step0 in cycle E+1 → last read (col3,row3) in cycle E+7 → DONE in cycle E+8. In that cycle done=1 and feed_valid=4'b1000 with mem[3][3].
- feed_valid pattern across cycles E+2..E+8: 0001, 0011, 0111, 1111, 1110, 1100, 1000; 0000 afterwards.
- hold=1 in FEED: step, mem controls, feed_data and feed_valid all keep their current values. A stalled array therefore sees a stable operand.
- hold=1 in DONE: stay in DONE, done stays high, until hold drops.
- hold=1 in IDLE: start is ignored.
- start while busy: ignored, no queuing.
- start and hold both high in IDLE: start is ignored.
- start in the DONE cycle: ignored. A new pass requires start in IDLE, so back-to-back passes have a 1-cycle IDLE gap minimum.
- All step arithmetic uses a 3-bit counter. The subtraction step-i is evaluated 3 bits wide, and only the low 2 bits drive mem_read_elem.

Decomposition:
- Shared package holds:
  - DATA_WIDTH and N defaults;
  - ROW_SEL_W=2;
  - STEP_W=3;
  - LAST_STEP=2N-2;
  - the state encoding localparams IDLE/FEED/DONE.
- One natural sub-module: skew_lane (one per column, generated N times). It takes step and column index, produces enable_i and row_i, and holds that column's feed_data/feed_valid register with the hold gate.
- The FSM and step counter live in the top module.

Test Plan:
- Reset/idle: assert rst_n low mid-FEED (step 3) → all outputs 0 within the same cycle; state IDLE; no done pulse.
- Full pass: preload mem[r][c]=16*r+c, pulse start → the valid pattern above over 7 cycles. feed_data col c at its k-th valid equals 16*k+c. done is a single pulse 8 cycles after the start edge.
- Address check: during FEED step 4 → mem_read_enable=4'b1110, mem_read_elem=8'b01_10_11_00 (col3=1, col2=2, col1=3, col0=0).
- Hold: pass as above, hold=1 for 3 cycles at step 2 → mem controls and feed outputs frozen. Pass completes 3 cycles late, with identical data sequence.
- Start ignored: pulse start at step 3 and in the DONE cycle → no restart. Next start in IDLE produces a clean full pass.
- Back-to-back: start held high continuously → passes repeat with done every 9 cycles, and feed_valid returns to 0000 for exactly one IDLE cycle between passes.

Source files
------------

// File: rtl/mem_skew_reader_pkg.sv
// Shared constants and state encoding for the skewed operand-memory reader.
package mem_skew_reader_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int N          = 4;
  localparam int ROW_SEL_W  = 2;
  localparam int STEP_W     = 3;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * N - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_skew_reader_if.sv
// Controller, memory-read and array-edge signals of the skewed reader.
// Handshake: start is a one-cycle request honoured only while the reader is idle and
// hold is low; busy covers the whole pass, and done pulses once (stretched by hold).
interface mem_skew_reader_if import mem_skew_reader_pkg::*; #(
  parameter int DATA_WIDTH = mem_skew_reader_pkg::DATA_WIDTH
);
  logic                      start;
  logic                      hold;
  logic                      busy;
  logic                      done;
  logic [N-1:0]              mem_read_enable;
  logic [N*ROW_SEL_W-1:0]    mem_read_elem;
  logic [N*DATA_WIDTH-1:0]   mem_data;
  logic [N*DATA_WIDTH-1:0]   feed_data;
  logic [N-1:0]              feed_valid;

  // The reader side.
  modport master (
    input  start, hold, mem_data,
    output busy, done, mem_read_enable, mem_read_elem, feed_data, feed_valid
  );

  // Controller, memory and array edge seen together.
  modport slave (
    output start, hold, mem_data,
    input  busy, done, mem_read_enable, mem_read_elem, feed_data, feed_valid
  );
endinterface

// File: rtl/mem_skew_reader_skew_lane.sv
// One memory column: derives its skewed row from the shared step and registers
// the returned operand with its valid flag, frozen while hold is high.
module skew_lane import mem_skew_reader_pkg::*; #(
  parameter int DATA_WIDTH = mem_skew_reader_pkg::DATA_WIDTH,
  parameter int COL        = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  feed_en,
  input  logic                  hold,
  input  logic [STEP_W-1:0]     step,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic [ROW_SEL_W-1:0]  rd_row,
  output logic [DATA_WIDTH-1:0] feed_data,
  output logic                  feed_valid
);

  logic [STEP_W-1:0] col_idx;
  logic [STEP_W-1:0] diff;

  assign col_idx = STEP_W'(COL);
  assign diff    = step - col_idx;

  // Column COL is active on steps COL..COL+N-1, reading row step-COL.
  assign rd_en  = feed_en && (step >= col_idx) && (diff <= STEP_W'(N - 1));
  assign rd_row = rd_en ? diff[ROW_SEL_W-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feed_valid <= 1'b0;
      feed_data  <= '0;
    end else if (!hold) begin
      feed_valid <= rd_en;
      feed_data  <= rd_en ? rd_data : '0;
    end
  end

endmodule

// File: rtl/mem_skew_reader.sv
// Read sequencer that walks the 4x4 operand memory in diagonal-skewed order
// and presents the wavefront, with per-column valids, to the array edge.
module mem_skew_reader import mem_skew_reader_pkg::*; #(
  parameter int DATA_WIDTH = mem_skew_reader_pkg::DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_skew_reader_if.master    bus,
  output state_t               state_dbg
);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                feed_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // hold freezes every state, including DONE so the done pulse stretches.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.hold) begin
          state_d = FEED;
          step_d  = '0;
        end
      end
      FEED: begin
        if (!bus.hold) begin
          if (step_q == LAST_STEP) begin
            state_d = DONE;
            step_d  = '0;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      DONE: begin
        if (!bus.hold) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  assign feed_en   = (state_q == FEED);
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign state_dbg = state_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .COL        (i)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .feed_en    (feed_en),
      .hold       (bus.hold),
      .step       (step_q),
      .rd_data    (bus.mem_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en      (bus.mem_read_enable[i]),
      .rd_row     (bus.mem_read_elem[i*ROW_SEL_W +: ROW_SEL_W]),
      .feed_data  (bus.feed_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .feed_valid (bus.feed_valid[i])
    );
  end

endmodule

// File: tb/tb_mem_skew_reader.sv
// Bench for mem_skew_reader: timeline table, hand-written corner sequences and
// randomized start/hold traffic checked against a pass-level reference model.
module tb_mem_skew_reader;
  import mem_skew_reader_pkg::*;

  localparam int DW = DATA_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_skew_reader_if bus ();
  state_t state_dbg;

  mem_skew_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Asynchronous memory: mem[row][col]; disabled columns return junk.
  logic [DW-1:0] mem [N][N];
  always_comb begin
    bus.mem_data = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.mem_read_enable[i])
        bus.mem_data[i*DW +: DW] = mem[bus.mem_read_elem[2*i +: 2]][i];
      else
        bus.mem_data[i*DW +: DW] = DW'(8'hA5) ^ DW'(i);
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 feeding, 2 done; t is the diagonal index of the pass.
  int               m_phase;
  int               m_t;
  logic [N-1:0]     m_fv;
  logic [N*DW-1:0]  m_fd;

  task automatic model_reset();
    m_phase = 0;
    m_t     = 0;
    m_fv    = '0;
    m_fd    = '0;
  endtask

  function automatic logic [N-1:0] model_en();
    logic [N-1:0] e;
    e = '0;
    for (int i = 0; i < N; i++)
      if (m_phase == 1 && m_t - i >= 0 && m_t - i <= N - 1) e[i] = 1'b1;
    return e;
  endfunction

  function automatic logic [2*N-1:0] model_elem();
    logic [2*N-1:0] r;
    logic [N-1:0]   e;
    int             row;
    r = '0;
    e = model_en();
    for (int i = 0; i < N; i++) begin
      row = m_t - i;
      if (e[i]) r[2*i +: 2] = row[1:0];
    end
    return r;
  endfunction

  task automatic model_edge(input logic s, input logic h);
    logic [N-1:0] e;
    e = model_en();
    if (!h) begin
      m_fv = e;
      for (int i = 0; i < N; i++)
        m_fd[i*DW +: DW] = e[i] ? mem[m_t - i][i] : '0;
    end
    case (m_phase)
      0: if (s && !h) begin m_phase = 1; m_t = 0; end
      1: if (!h) begin
           if (m_t == 2*N - 2) m_phase = 2;
           else m_t = m_t + 1;
         end
      default: if (!h) m_phase = 0;
    endcase
  endtask

  task automatic check_model(input string tag);
    check({tag, ".busy"},  64'(bus.busy),            64'(m_phase != 0));
    check({tag, ".done"},  64'(bus.done),            64'(m_phase == 2));
    check({tag, ".en"},    64'(bus.mem_read_enable), 64'(model_en()));
    check({tag, ".elem"},  64'(bus.mem_read_elem),   64'(model_elem()));
    check({tag, ".fv"},    64'(bus.feed_valid),      64'(m_fv));
    check({tag, ".fd"},    64'(bus.feed_data),       64'(m_fd));
  endtask

  // ---------------- driver ----------------
  // Inputs change at the falling edge; outputs are read at the next falling edge.
  task automatic cycle(input logic s, input logic h);
    bus.start = s;
    bus.hold  = h;
    @(posedge clk);
    model_edge(s, h);
    @(negedge clk);
  endtask

  // ---------------- timeline table ----------------
  typedef struct {
    logic         start;
    logic         hold;
    logic         busy;
    logic         done;
    logic [3:0]   en;
    logic [7:0]   elem;
    logic [3:0]   fv;
  } vec_t;

  vec_t tbl [10];

  task automatic fill_table();
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 8'h00, 4'b0000};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 8'h01, 4'b0001};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0111, 8'h06, 4'b0011};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 8'h1B, 4'b0111};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b1110, 8'h6C, 4'b1111};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 8'hB0, 4'b1110};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 8'hC0, 4'b1100};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 8'h00, 4'b1000};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000};
  endtask

  task automatic preload_ramp();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mem[r][c] = DW'(16 * r + c);
  endtask

  // Applies the table; with the ramp preload column c's k-th operand is 16k+c.
  task automatic run_table(input string tag);
    logic [N*DW-1:0] exp_fd;
    int              k;
    for (int j = 0; j < 10; j++) begin
      cycle(tbl[j].start, tbl[j].hold);
      check({tag, ".busy"}, 64'(bus.busy),            64'(tbl[j].busy));
      check({tag, ".done"}, 64'(bus.done),            64'(tbl[j].done));
      check({tag, ".en"},   64'(bus.mem_read_enable), 64'(tbl[j].en));
      check({tag, ".elem"}, 64'(bus.mem_read_elem),   64'(tbl[j].elem));
      check({tag, ".fv"},   64'(bus.feed_valid),      64'(tbl[j].fv));
      exp_fd = '0;
      for (int c = 0; c < N; c++) begin
        k = (j - 1) - c;
        if (j >= 1 && j <= 7 && k >= 0 && k <= N - 1) exp_fd[c*DW +: DW] = DW'(16 * k + c);
      end
      check({tag, ".fd"}, 64'(bus.feed_data), 64'(exp_fd));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int done_at;
    int n_done;
    int last_done;
    int gap;
    int idle_run;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    preload_ramp();
    model_reset();
    fill_table();
    repeat (2) @(negedge clk);

    check("reset.busy",  64'(bus.busy),            64'(0));
    check("reset.done",  64'(bus.done),            64'(0));
    check("reset.en",    64'(bus.mem_read_enable), 64'(0));
    check("reset.elem",  64'(bus.mem_read_elem),   64'(0));
    check("reset.fv",    64'(bus.feed_valid),      64'(0));
    check("reset.fd",    64'(bus.feed_data),       64'(0));
    check("reset.state", 64'(state_dbg),           64'(IDLE));
    rst_n = 1'b1;
    cycle(1'b0, 1'b0);
    check_model("idle");

    // Full pass with timeline/address/data checks.
    run_table("pass");

    // Hold for three cycles once step 2 is presented.
    done_at = -1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      cycle(cyc == 0, cyc >= 3 && cyc <= 5);
      check_model("hold");
      if (cyc >= 3 && cyc <= 5) begin
        check("hold.frozen_en", 64'(bus.mem_read_enable), 64'(4'b0111));
        check("hold.frozen_fv", 64'(bus.feed_valid),      64'(4'b0011));
      end
      if (bus.done && done_at < 0) done_at = cyc + 1;
    end
    check("hold.done_cycle", 64'(done_at), 64'(11));

    // Start at step 3 and in the DONE cycle must not restart the pass.
    n_done = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      cycle(cyc == 0 || cyc == 4 || cyc == 8, 1'b0);
      check_model("ignore");
      if (bus.done) n_done++;
    end
    check("ignore.done_count", 64'(n_done), 64'(1));
    check("ignore.state", 64'(state_dbg), 64'(IDLE));
    run_table("clean");

    // Start held high: a pass every 9 cycles with a single idle cycle between.
    last_done = -1;
    n_done    = 0;
    idle_run  = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      cycle(1'b1, 1'b0);
      check_model("b2b");
      if (!bus.busy) begin
        idle_run++;
        check("b2b.idle_fv", 64'(bus.feed_valid), 64'(0));
      end else if (idle_run != 0) begin
        if (cyc > 1) check("b2b.idle_run", 64'(idle_run), 64'(1));
        idle_run = 0;
      end
      if (bus.done) begin
        if (last_done >= 0) begin
          gap = cyc - last_done;
          check("b2b.done_gap", 64'(gap), 64'(9));
        end
        last_done = cyc;
        n_done++;
      end
    end
    check("b2b.done_count", 64'(n_done), 64'(4));
    repeat (10) begin
      cycle(1'b0, 1'b0);
      check_model("drain");
    end

    // Randomized start/hold traffic over random memory contents.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mem[r][c] = DW'($urandom);
    for (int cyc = 0; cyc < 500; cyc++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      check_model("rand");
    end
    repeat (12) begin
      cycle(1'b0, 1'b0);
      check_model("rand_drain");
    end

    // Asynchronous reset at step 3 clears everything without a done pulse.
    preload_ramp();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("arst.pre_en", 64'(bus.mem_read_enable), 64'(4'b1111));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.busy",  64'(bus.busy),            64'(0));
    check("arst.done",  64'(bus.done),            64'(0));
    check("arst.en",    64'(bus.mem_read_enable), 64'(0));
    check("arst.elem",  64'(bus.mem_read_elem),   64'(0));
    check("arst.fv",    64'(bus.feed_valid),      64'(0));
    check("arst.fd",    64'(bus.feed_data),       64'(0));
    check("arst.state", 64'(state_dbg),           64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      cycle(1'b0, 1'b0);
      check_model("arst_after");
      if (bus.done) n_done++;
    end
    check("arst.no_done", 64'(n_done), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
